// File: rtl/aha_tlx_train_pkg.sv
// Shared definitions for the TLX lane trainer: FSM encodings, width helper,
// and the parameter legality limits.
package aha_tlx_train_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRAIN  = 2'b01,
        ST_FINISH = 2'b10
    } train_state_e;

    // Smallest legal training pattern and lock threshold.
    localparam int unsigned MIN_PAT_W       = 4;
    localparam int unsigned MIN_LOCK_THRESH = 1;

    // Bits needed to hold values 0..v-1 (at least one bit).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'(1) << r) < 64'(v))) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/aha_tlx_lane_checker.sv
// One receive lane: shift register, pattern compare, phase/run tracking for
// word lock, and saturating match (and optionally missed-match) counters.
// Optional feature macro: AHA_TLX_TRAIN_ERRCNT_EN adds err_count_o.
module aha_tlx_lane_checker
    import aha_tlx_train_pkg::*;
#(
    parameter int unsigned PAT_W       = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned LOCK_THRESH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             shift_en_i,
    input  logic             clear_i,
    input  logic             fill_full_i,
    input  logic             d_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             locked_o,
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
    output logic [CNT_W-1:0] err_count_o,
`endif
    output logic [CNT_W-1:0] match_count_o
);

    localparam int unsigned PH_W  = clog2(PAT_W);
    localparam int unsigned RUN_W = clog2(LOCK_THRESH + 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PAT_W - 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_THRESH);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             locked_q;
    logic             match_c;
    logic             slot_c;
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
`endif

    // Compare on the registered window; slot_c marks where the next aligned match is due.
    assign match_c = fill_full_i && (sr_q == pattern_i);
    assign slot_c  = (ph_q == PH_LAST);

    // Next-state for window, phase, run length and counters; clear wins over shifting.
    always_comb begin
        sr_d   = sr_q;
        ph_d   = ph_q;
        run_d  = run_q;
        mcnt_d = mcnt_q;
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
        ecnt_d = ecnt_q;
`endif
        if (clear_i) begin
            sr_d   = '0;
            ph_d   = '0;
            run_d  = '0;
            mcnt_d = '0;
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
            ecnt_d = '0;
`endif
        end else if (shift_en_i) begin
            sr_d = {d_i, sr_q[PAT_W-1:1]};
            if (match_c) begin
                ph_d = '0;
                if ((run_q != '0) && slot_c) begin
                    run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
                end else begin
                    run_d = RUN_W'(1);
                end
                if (mcnt_q != '1) begin
                    mcnt_d = mcnt_q + CNT_W'(1);
                end
            end else begin
                ph_d = slot_c ? '0 : ph_q + PH_W'(1);
                if (slot_c) begin
                    run_d = '0;
                end
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
                if (slot_c && (run_q != '0) && (ecnt_q != '1)) begin
                    ecnt_d = ecnt_q + CNT_W'(1);
                end
`endif
            end
        end
    end

    // Lane state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q     <= '0;
            ph_q     <= '0;
            run_q    <= '0;
            mcnt_q   <= '0;
            locked_q <= 1'b0;
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
            ecnt_q   <= '0;
`endif
        end else begin
            sr_q     <= sr_d;
            ph_q     <= ph_d;
            run_q    <= run_d;
            mcnt_q   <= mcnt_d;
            locked_q <= (run_d >= RUN_MAX);
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
            ecnt_q   <= ecnt_d;
`endif
        end
    end

    assign locked_o      = locked_q;
    assign match_count_o = mcnt_q;
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
    assign err_count_o   = ecnt_q;
`endif

endmodule

// File: rtl/aha_tlx_lane_trainer.sv
// Multi-lane TLX receive training checker: START/CLEAR edge detect, run FSM,
// bit index / window fill / word counters, and one lane checker per lane.
// Optional feature macro: AHA_TLX_TRAIN_ERRCNT_EN adds the ERR_COUNT port.
module aha_tlx_lane_trainer
    import aha_tlx_train_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned PAT_W       = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned LOCK_THRESH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [LANES-1:0]       D_IN,
    input  logic                   START,
    input  logic                   CLEAR,
    input  logic [PAT_W-1:0]       PATTERN,
    input  logic [CNT_W-1:0]       LENGTH,
    input  logic                   AUTO_STOP,
    output logic                   DONE,
    output logic                   ACTIVE,
    output logic [LANES-1:0]       LOCKED,
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
    output logic [LANES*CNT_W-1:0] ERR_COUNT,
`endif
    output logic [LANES*CNT_W-1:0] MATCH_COUNT
);

    localparam int unsigned IDX_W  = clog2(PAT_W);
    localparam int unsigned FILL_W = clog2(PAT_W + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Reject illegal configurations at elaboration.
    if ((PAT_W < MIN_PAT_W) || (LOCK_THRESH < MIN_LOCK_THRESH)) begin : g_param_err
        $error("aha_tlx_lane_trainer: illegal PAT_W or LOCK_THRESH");
    end

    train_state_e      state_q, state_d;
    logic              start_q, clear_q;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              st_c, cl_c, restart_c, stop_c, train_c;

    assign st_c      = START & ~start_q;
    assign cl_c      = CLEAR & ~clear_q;
    assign restart_c = st_c | cl_c;
    assign train_c   = (state_q == ST_TRAIN);
    assign stop_c    = AUTO_STOP && (words_q == LENGTH);

    // Run FSM next-state and sticky DONE; CLEAR outranks START in every state.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        if (cl_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end else if (st_c) begin
            state_d = ST_TRAIN;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_TRAIN: begin
                    if (stop_c) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end
                end
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Bit index, window fill and word counters advance only while training.
    always_comb begin
        idx_d   = idx_q;
        fill_d  = fill_q;
        words_d = words_q;
        if (restart_c) begin
            idx_d   = '0;
            fill_d  = '0;
            words_d = '0;
        end else if (train_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
            if ((idx_q == IDX_LAST) && (words_q != '1)) begin
                words_d = words_q + CNT_W'(1);
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            clear_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            fill_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= START;
            clear_q <= CLEAR;
            done_q  <= done_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            words_q <= words_d;
        end
    end

    assign DONE   = done_q;
    assign ACTIVE = train_c && !stop_c;

    // One checker per lane sharing the common control.
    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        aha_tlx_lane_checker #(
            .PAT_W       (PAT_W),
            .CNT_W       (CNT_W),
            .LOCK_THRESH (LOCK_THRESH)
        ) u_chk (
            .clk_i         (CLK),
            .rst_i         (RESET),
            .shift_en_i    (train_c),
            .clear_i       (restart_c),
            .fill_full_i   (fill_q == FILL_FULL),
            .d_i           (D_IN[i]),
            .pattern_i     (PATTERN),
            .locked_o      (LOCKED[i]),
`ifdef AHA_TLX_TRAIN_ERRCNT_EN
            .err_count_o   (ERR_COUNT[i*CNT_W +: CNT_W]),
`endif
            .match_count_o (MATCH_COUNT[i*CNT_W +: CNT_W])
        );
    end

endmodule
